// File: rtl/alu_pkg.sv
// Shared ALU op encodings and the multiply sequencer state type.
package alu_pkg;
  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_INC  = 2'b10,
    ALU_PASS = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_RUN,
    MS_DONE
  } mul_state_t;
endpackage

// File: rtl/alu.sv
// Shared execute-stage arithmetic ALU: add/sub/inc/pass on a, carry/borrow on c_out.
// Latency: combinational. Backpressure: none.
// Implementation note: PASS forces c_out to 0, so the multiplier's shift-in bit stays clean.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       s,
  input  logic             c_in,
  output logic [WIDTH-1:0] out,
  output logic             c_out
);
  logic [WIDTH:0] res;

  always_comb begin
    res = '0;
    case (alu_op_t'(s))
      ALU_ADD:  res = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
      ALU_SUB:  res = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, c_in};
      ALU_INC:  res = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
      default:  res = {1'b0, a};
    endcase
  end

  assign out   = res[WIDTH-1:0];
  assign c_out = res[WIDTH];
endmodule

// File: rtl/alu_mul_sequencer.sv
// Unsigned shift-add multiplier driving the shared ALU for WIDTH steps; ALU_MUL_OVF_EN adds ovf.
// Latency: res_valid rises WIDTH+1 edges after accept, counting the accept edge itself.
// Backpressure: product held in DONE until res_ready; start_ready low outside IDLE.
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [1:0]           alu_s,
  output logic                 alu_c_in,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic                 alu_c_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*WIDTH-1:0]   product
`ifdef ALU_MUL_OVF_EN
  ,
  output logic                 ovf
`endif
);
  localparam int CW = $clog2(WIDTH + 1);

  mul_state_t       state, state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MS_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MS_IDLE: if (start_valid)     state_nxt = MS_RUN;
      MS_RUN:  if (cnt == CW'(1))   state_nxt = MS_DONE;
      MS_DONE: if (res_ready)       state_nxt = MS_IDLE;
      default:                      state_nxt = MS_IDLE;
    endcase
  end

  // acc_lo doubles as the multiplier shift register: its LSB picks ADD vs PASS each step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else if (state == MS_IDLE && start_valid) begin
      mcand  <= op_a;
      acc_hi <= '0;
      acc_lo <= op_b;
      cnt    <= CW'(WIDTH);
    end else if (state == MS_RUN) begin
      acc_hi <= {alu_c_out, alu_out[WIDTH-1:1]};
      acc_lo <= {alu_out[0], acc_lo[WIDTH-1:1]};
      cnt    <= cnt - CW'(1);
    end
  end

  always_comb begin
    start_ready = 1'b0;
    res_valid   = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_s       = ALU_PASS;
    product     = '0;
    case (state)
      MS_IDLE: start_ready = 1'b1;
      MS_RUN: begin
        alu_a = acc_hi;
        alu_b = mcand;
        alu_s = acc_lo[0] ? ALU_ADD : ALU_PASS;
      end
      MS_DONE: begin
        res_valid = 1'b1;
        product   = {acc_hi, acc_lo};
      end
      default: ;
    endcase
  end

  assign alu_c_in = 1'b0;

`ifdef ALU_MUL_OVF_EN
  assign ovf = res_valid && (product[2*WIDTH-1:WIDTH] != '0);
`endif
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed self-checking bench for alu_mul_sequencer wired to the shared ALU (WIDTH=8).
module tb_alu_mul_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [7:0]  op_a = '0;
  logic [7:0]  op_b = '0;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic [1:0]  alu_s;
  logic        alu_c_in, alu_c_out;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] product;
`ifdef ALU_MUL_OVF_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_mul_sequencer #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_c_in(alu_c_in),
    .alu_out(alu_out), .alu_c_out(alu_c_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .product(product)
`ifdef ALU_MUL_OVF_EN
    , .ovf(ovf)
`endif
  );

  alu #(.WIDTH(8)) u_alu (
    .a(alu_a), .b(alu_b), .s(alu_s), .c_in(alu_c_in),
    .out(alu_out), .c_out(alu_c_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one operation and waits for res_valid; lat counts edges including the accept edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat);
    int w = 0;
    while (!start_ready && w < 20) begin
      tick();
      w++;
    end
    op_a = a;
    op_b = b;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    op_a = 8'($urandom);
    op_b = 8'($urandom);
    lat = 1;
    while (!res_valid && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0 || product !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_hs: start_ready=%b res_valid=%b product=%h required 1 0 0000", start_ready, res_valid, product);
    end
    n_checks++;
    if (alu_a !== 8'h0 || alu_b !== 8'h0 || alu_s !== ALU_PASS || alu_c_in !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_alu: a=%h b=%h s=%b c_in=%b required 00 00 11 0", alu_a, alu_b, alu_s, alu_c_in);
    end
`ifdef ALU_MUL_OVF_EN
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf: got %b required 0", ovf);
    end
`endif
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    op_a = 8'd13;
    op_b = 8'd11;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    op_a = 8'hAA;
    op_b = 8'h55;
    // First step: acc_hi=0, multiplier LSB=1 -> ADD 0+13.
    n_checks++;
    if (alu_s !== ALU_ADD || alu_a !== 8'd0 || alu_b !== 8'd13 || start_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_step1: s=%b a=%0d b=%0d sr=%b required 00 0 13 0", alu_s, alu_a, alu_b, start_ready);
    end
    tick();
    // After step 1: acc_hi=13>>1=6, acc_lo=8'h85 (LSB 1) -> ADD again.
    n_checks++;
    if (alu_s !== ALU_ADD || alu_a !== 8'd6 || alu_b !== 8'd13) begin
      n_fail++;
      $display("FAIL basic_step2: s=%b a=%0d b=%0d required 00 6 13", alu_s, alu_a, alu_b);
    end
    lat = 2;
    while (!res_valid && lat < 30) begin
      tick();
      lat++;
    end
    n_checks++;
    if (lat != 9) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d edges required 9", lat);
    end
    n_checks++;
    if (product !== 16'h008F) begin
      n_fail++;
      $display("FAIL basic_product: got %h required 008f", product);
    end
`ifdef ALU_MUL_OVF_EN
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ovf: got %b required 0", ovf);
    end
`endif
    release_result();
    n_checks++;
    if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_release: res_valid=%b start_ready=%b required 0 1", res_valid, start_ready);
    end
  endtask

  task automatic test_max();
    int lat;
    run_op(8'd255, 8'd255, lat);
    n_checks++;
    if (lat != 9 || product !== 16'hFE01) begin
      n_fail++;
      $display("FAIL max_product: got %h lat %0d required fe01 lat 9", product, lat);
    end
`ifdef ALU_MUL_OVF_EN
    n_checks++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL max_ovf: got %b required 1", ovf);
    end
`endif
    release_result();
  endtask

  task automatic test_zero();
    logic [7:0] za [2] = '{8'd0, 8'd1};
    logic [7:0] zb [2] = '{8'd200, 8'd0};
    int lat;
    for (int i = 0; i < 2; i++) begin
      run_op(za[i], zb[i], lat);
      n_checks++;
      if (lat != 9 || res_valid !== 1'b1 || product !== 16'h0) begin
        n_fail++;
        $display("FAIL zero_%0d: product=%h lat=%0d rv=%b required 0000 9 1", i, product, lat, res_valid);
      end
`ifdef ALU_MUL_OVF_EN
      n_checks++;
      if (ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_ovf_%0d: got %b required 0", i, ovf);
      end
`endif
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    run_op(8'd5, 8'd9, lat);
    for (int i = 0; i < 5; i++) begin
      start_valid = i[0];
      op_a = 8'd3;
      op_b = 8'd3;
      tick();
      if (res_valid !== 1'b1 || product !== 16'h002D || start_ready !== 1'b0) bad++;
    end
    start_valid = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d unstable cycles required 0 (last rv=%b prod=%h sr=%b)", bad, res_valid, product, start_ready);
    end
    release_result();
    tick();
    n_checks++;
    if (res_valid !== 1'b0 || start_ready !== 1'b1 || alu_s !== ALU_PASS) begin
      n_fail++;
      $display("FAIL bp_idle: rv=%b sr=%b s=%b required 0 1 11 (no stray accept)", res_valid, start_ready, alu_s);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int pulses = 0;
    op_a = 8'd3;
    op_b = 8'd5;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0 || product !== 16'h0 || alu_s !== ALU_PASS || alu_a !== 8'h0) begin
      n_fail++;
      $display("FAIL rst_mid: sr=%b rv=%b prod=%h s=%b a=%h required 1 0 0000 11 00", start_ready, res_valid, product, alu_s, alu_a);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid !== 1'b0) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL rst_no_pulse: res_valid high %0d cycles required 0", pulses);
    end
    run_op(8'd6, 8'd7, lat);
    n_checks++;
    if (lat != 9 || product !== 16'h002A) begin
      n_fail++;
      $display("FAIL rst_new_op: product=%h lat=%0d required 002a 9", product, lat);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat = 1;
    op_a = 8'd16;
    op_b = 8'd16;
    start_valid = 1'b1;
    res_ready = 1'b1;
    tick();
    op_a = 8'd15;
    op_b = 8'd17;
    while (!res_valid && lat < 30) begin
      tick();
      lat++;
    end
    n_checks++;
    if (lat != 9 || product !== 16'h0100) begin
      n_fail++;
      $display("FAIL b2b_first: product=%h lat=%0d required 0100 9", product, lat);
    end
`ifdef ALU_MUL_OVF_EN
    n_checks++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first_ovf: got %b required 1", ovf);
    end
`endif
    tick();
    n_checks++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: sr=%b rv=%b required 1 0", start_ready, res_valid);
    end
    tick();
    start_valid = 1'b0;
    n_checks++;
    if (start_ready !== 1'b0 || alu_b !== 8'd15) begin
      n_fail++;
      $display("FAIL b2b_accept: sr=%b alu_b=%0d required 0 15", start_ready, alu_b);
    end
    lat = 1;
    while (!res_valid && lat < 30) begin
      tick();
      lat++;
    end
    n_checks++;
    if (lat != 9 || product !== 16'h00FF) begin
      n_fail++;
      $display("FAIL b2b_second: product=%h lat=%0d required 00ff 9", product, lat);
    end
`ifdef ALU_MUL_OVF_EN
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second_ovf: got %b required 0", ovf);
    end
`endif
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
